// File: rtl/lw_sha_axi4_regif_if.sv
// lw_sha_axi4_regif_if: AXI4 slave-side bus bundle for the SHA/HMAC register front end.
interface lw_sha_axi4_regif_if #(
    parameter int ADDR_W     = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [3:0]            awid;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        output wdata, wlast, wvalid, bready,
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        input  wdata, wlast, wvalid, bready,
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/lw_sha_axi4_regif.sv
// lw_sha_axi4_regif: AXI4 register front end of the SHA/HMAC core (CFG/CTL/STS/HASH/DIN/KEY).
module lw_sha_axi4_regif #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 12,
    parameter int KEY_WORDS  = 16,
    parameter int DIG_WORDS  = 16
) (
    input  logic                            aclk,
    input  logic                            areset,
    lw_sha_axi4_regif_if.slave              axi,
    output logic                            irq,
    input  logic [3:0]                      random_i,
    output logic [4:0]                      core_mode_o,
    output logic                            core_init_o,
    output logic                            core_last_o,
    output logic [DATA_WIDTH-1:0]           core_din_o,
    output logic                            core_din_valid_o,
    input  logic                            core_din_ready_i,
    output logic [KEY_WORDS*DATA_WIDTH-1:0] core_key_o,
    input  logic                            core_busy_i,
    input  logic                            core_done_i,
    input  logic [DIG_WORDS*DATA_WIDTH-1:0] core_digest_i,
    output logic                            core_srst_o,
    output logic [3:0]                      core_random_o
);
    localparam logic [ADDR_W-1:0] A_CFG  = 'h010;
    localparam logic [ADDR_W-1:0] A_CTL  = 'h020;
    localparam logic [ADDR_W-1:0] A_STS  = 'h030;
    localparam logic [ADDR_W-1:0] A_HASH = 'h100;
    localparam logic [ADDR_W-1:0] A_DIN  = 'h140;
    localparam logic [ADDR_W-1:0] A_KEY  = 'h150;
    localparam int KI = $clog2(KEY_WORDS);
    localparam int HI = $clog2(DIG_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
    typedef enum logic {R_IDLE, R_DATA} rst_t;

    wst_t                  w_state, w_next;
    rst_t                  r_state, r_next;
    logic                  up;
    logic [ADDR_W-1:0]     w_addr;
    logic [7:0]            w_len, w_cnt;
    logic                  w_drop, w_err;
    logic [ADDR_W-1:0]     r_addr, rd_addr;
    logic [7:0]            r_len, r_cnt;
    logic                  r_incr;
    logic [DATA_WIDTH-1:0] cfg, rd_val;
    logic [1:0]            ctl;
    logic                  done, rd_err, rd_hash;
    logic [KI-1:0]         kidx;
    logic [DATA_WIDTH-1:0] kw [KEY_WORDS];
    logic [3:0]            rnd;
    logic                  aw_hs, w_hs, w_end, ar_hs, r_hs;
    logic                  is_din, w_beat0, cfg_wr, ctl_wr, key_wr, aw_busy_din;

    assign aw_hs       = axi.awvalid && axi.awready;
    assign w_hs        = axi.wvalid && axi.wready;
    assign w_end       = w_hs && (axi.wlast || w_cnt == w_len);
    assign ar_hs       = axi.arvalid && axi.arready;
    assign r_hs        = axi.rvalid && axi.rready;
    assign is_din      = w_addr == A_DIN;
    assign aw_busy_din = axi.awaddr == A_DIN && core_busy_i;
    assign w_beat0     = w_hs && w_cnt == 8'd0 && !w_err;
    assign cfg_wr      = w_beat0 && w_addr == A_CFG;
    assign ctl_wr      = w_beat0 && w_addr == A_CTL;
    assign key_wr      = w_hs && w_addr == A_KEY;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  w_next = aw_hs ? W_DATA : W_IDLE;
            W_DATA:  w_next = w_end ? W_RESP : W_DATA;
            W_RESP:  w_next = axi.bready ? W_IDLE : W_RESP;
            default: w_next = W_IDLE;
        endcase
    end

    // A drained DIN burst must accept beats even when the core is not ready.
    always_comb begin
        axi.awready      = up && w_state == W_IDLE;
        axi.wready       = w_state == W_DATA && (!is_din || w_drop || core_din_ready_i);
        axi.bvalid       = w_state == W_RESP;
        axi.bresp        = (w_state == W_RESP && w_err) ? 2'b10 : 2'b00;
        core_din_valid_o = w_state == W_DATA && is_din && !w_drop && axi.wvalid && core_din_ready_i;
        core_din_o       = axi.wdata;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_addr <= '0;
            w_len  <= '0;
            w_cnt  <= '0;
            w_drop <= 1'b0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_addr <= axi.awaddr;
            w_len  <= axi.awlen;
            w_cnt  <= '0;
            w_drop <= aw_busy_din;
            w_err  <= aw_busy_din || !(axi.awaddr == A_CFG || axi.awaddr == A_CTL ||
                                       axi.awaddr == A_DIN || axi.awaddr == A_KEY);
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
        end
    end

    // Soft reset (CFG[31]) holds CTL, key, key index and the done flag cleared.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            up          <= 1'b0;
            rnd         <= '0;
            cfg         <= '0;
            ctl         <= '0;
            core_init_o <= 1'b0;
            done        <= 1'b0;
            kidx        <= '0;
            for (int i = 0; i < KEY_WORDS; i++) kw[i] <= '0;
        end else begin
            up          <= 1'b1;
            rnd         <= random_i;
            cfg         <= cfg_wr ? axi.wdata : cfg;
            core_init_o <= ctl_wr && axi.wdata[0] && !cfg[DATA_WIDTH-1];
            if (cfg[DATA_WIDTH-1]) begin
                ctl  <= '0;
                done <= 1'b0;
                kidx <= '0;
                for (int i = 0; i < KEY_WORDS; i++) kw[i] <= '0;
            end else begin
                ctl  <= ctl_wr ? axi.wdata[1:0] : ctl;
                done <= core_done_i || (done && !ctl_wr);
                if (ctl_wr && axi.wdata[0]) begin
                    kidx <= '0;
                end else if (key_wr) begin
                    kw[kidx] <= axi.wdata;
                    kidx     <= kidx + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
        assign core_key_o[DATA_WIDTH*(KEY_WORDS-1-g) +: DATA_WIDTH] = kw[g];
    end

    assign irq           = done;
    assign core_mode_o   = cfg[4:0];
    assign core_srst_o   = cfg[DATA_WIDTH-1];
    assign core_last_o   = ctl[1];
    assign core_random_o = rnd;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  r_next = ar_hs ? R_DATA : R_IDLE;
            R_DATA:  r_next = (r_hs && axi.rlast) ? R_IDLE : R_DATA;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        axi.arready = up && r_state == R_IDLE;
        axi.rvalid  = r_state == R_DATA;
    end

    // Read data is looked up for the next beat's address and registered, so it holds under stall.
    always_comb begin
        rd_addr = ar_hs ? axi.araddr : (r_incr ? r_addr + ADDR_W'(4) : r_addr);
        rd_hash = rd_addr >= A_HASH && rd_addr < A_HASH + ADDR_W'(4 * DIG_WORDS) && rd_addr[1:0] == 2'b00;
        rd_val  = rd_addr == A_CFG ? cfg :
                  rd_addr == A_CTL ? {{(DATA_WIDTH-2){1'b0}}, ctl} :
                  rd_addr == A_STS ? {{(DATA_WIDTH-5){1'b0}}, core_busy_i, 3'b000, done} :
                  rd_hash          ? core_digest_i[DATA_WIDTH*rd_addr[2 +: HI] +: DATA_WIDTH] :
                                     '0;
        rd_err  = !(rd_addr == A_CFG || rd_addr == A_CTL || rd_addr == A_STS || rd_hash);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_incr    <= 1'b0;
            axi.rdata <= '0;
            axi.rresp <= '0;
            axi.rlast <= 1'b0;
        end else if (ar_hs) begin
            r_addr    <= axi.araddr;
            r_len     <= axi.arlen;
            r_cnt     <= '0;
            r_incr    <= axi.arburst != 2'b00;
            axi.rdata <= rd_val;
            axi.rresp <= {rd_err, 1'b0};
            axi.rlast <= axi.arlen == 8'd0;
        end else if (r_hs && !axi.rlast) begin
            r_addr    <= rd_addr;
            r_cnt     <= r_cnt + 8'd1;
            axi.rdata <= rd_val;
            axi.rresp <= {rd_err, 1'b0};
            axi.rlast <= r_cnt + 8'd1 == r_len;
        end
    end
endmodule

// File: tb/tb_lw_sha_axi4_regif.sv
// tb_lw_sha_axi4_regif: directed AXI4 bench for the SHA/HMAC register front end.
module tb_lw_sha_axi4_regif;
    logic         aclk = 1'b0;
    logic         areset;
    logic         irq;
    logic [3:0]   random_i, core_random_o;
    logic [4:0]   core_mode_o;
    logic         core_init_o, core_last_o, core_din_valid_o, core_din_ready_i;
    logic [31:0]  core_din_o;
    logic [511:0] core_key_o, core_digest_i, exp_key;
    logic         core_busy_i, core_done_i, core_srst_o;
    logic [31:0]  wbuf [16];
    logic [31:0]  rbuf [16];
    logic [1:0]   rrsp [16];
    logic         rlst [16];
    logic [31:0]  din_log [64];
    logic [31:0]  kbuf [16];
    logic [31:0]  dbuf [16];
    logic [1:0]   resp;
    logic         done_on_w = 1'b0;
    int           checks = 0, errors = 0, din_n = 0, init_n = 0, base;

    lw_sha_axi4_regif_if axi ();

    lw_sha_axi4_regif dut (
        .aclk(aclk), .areset(areset), .axi(axi), .irq(irq), .random_i(random_i),
        .core_mode_o(core_mode_o), .core_init_o(core_init_o), .core_last_o(core_last_o),
        .core_din_o(core_din_o), .core_din_valid_o(core_din_valid_o), .core_din_ready_i(core_din_ready_i),
        .core_key_o(core_key_o), .core_busy_i(core_busy_i), .core_done_i(core_done_i),
        .core_digest_i(core_digest_i), .core_srst_o(core_srst_o), .core_random_o(core_random_o)
    );

    always #5 aclk = ~aclk;

    always begin
        @(negedge aclk);
        #1;
        if (core_din_valid_o && core_din_ready_i && din_n < 64) begin
            din_log[din_n] = core_din_o;
            din_n++;
        end
        if (core_init_o) init_n++;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        checks++;
        errors++;
        $error("FAIL timeout %s", tag);
    endtask

    task automatic wr(input logic [11:0] a, input int len, output logic [1:0] r);
        int n;
        @(negedge aclk);
        axi.awaddr = a; axi.awlen = 8'(len); axi.awsize = 3'd2; axi.awburst = 2'b01; axi.awvalid = 1'b1;
        #1; n = 0;
        while (!axi.awready && n < 50) begin @(negedge aclk); #1; n++; end
        if (!axi.awready) tmo("aw");
        @(posedge aclk); @(negedge aclk);
        axi.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            axi.wdata = wbuf[i]; axi.wlast = (i == len); axi.wvalid = 1'b1;
            if (i == 0) core_done_i = done_on_w;
            #1; n = 0;
            while (!axi.wready && n < 50) begin @(negedge aclk); #1; n++; end
            if (!axi.wready) tmo("w");
            @(posedge aclk); @(negedge aclk);
            core_done_i = 1'b0;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.bready = 1'b1;
        #1; n = 0;
        while (!axi.bvalid && n < 50) begin @(negedge aclk); #1; n++; end
        if (!axi.bvalid) tmo("b");
        r = axi.bresp;
        @(posedge aclk); @(negedge aclk);
        axi.bready = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input int len, input int stall);
        int n;
        logic [31:0] hold;
        @(negedge aclk);
        axi.araddr = a; axi.arlen = 8'(len); axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
        #1; n = 0;
        while (!axi.arready && n < 50) begin @(negedge aclk); #1; n++; end
        if (!axi.arready) tmo("ar");
        @(posedge aclk); @(negedge aclk);
        axi.arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == stall) begin
                #1; hold = axi.rdata;
                repeat (3) @(negedge aclk);
                #1; chk("rdata_stall", {480'd0, axi.rdata}, {480'd0, hold});
            end
            axi.rready = 1'b1;
            #1; n = 0;
            while (!axi.rvalid && n < 50) begin @(negedge aclk); #1; n++; end
            if (!axi.rvalid) tmo("r");
            rbuf[i] = axi.rdata; rrsp[i] = axi.rresp; rlst[i] = axi.rlast;
            @(posedge aclk); @(negedge aclk);
            axi.rready = 1'b0;
        end
    endtask

    initial begin
        areset = 1'b1;
        axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awid = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        random_i = '0; core_din_ready_i = 1'b1; core_busy_i = 1'b0; core_done_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dbuf[i] = 32'hd1e50000 + i * 32'h00010203;
            core_digest_i[32*i +: 32] = dbuf[i];
        end
        #2;
        chk("rst_awready", axi.awready, 0);
        chk("rst_arready", axi.arready, 0);
        chk("rst_valids", {axi.bvalid, axi.rvalid, axi.wready}, 0);
        chk("rst_irq_mode", {irq, core_mode_o, core_key_o}, 0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk); #1;
        chk("idle_ready", {axi.awready, axi.arready}, 2'b11);

        wbuf[0] = 32'h80000000; wr(12'h010, 0, resp);
        chk("cfg_bresp", resp, 2'b00);
        chk("srst_high", core_srst_o, 1);
        wbuf[0] = 32'h0; wr(12'h010, 0, resp);
        chk("srst_low", core_srst_o, 0);
        wbuf[0] = 32'h15; wr(12'h010, 0, resp);
        rd(12'h010, 0, -1);
        chk("cfg_read", {rrsp[0], rbuf[0]}, {2'b00, 32'h15});
        chk("core_mode", core_mode_o, 5'h15);

        init_n = 0;
        wbuf[0] = 32'h1; wr(12'h020, 0, resp);
        repeat (4) @(negedge aclk);
        chk("init_pulse_cycles", init_n, 1);

        kbuf[0] = 32'h09a09c09; kbuf[1] = 32'hc989a090; kbuf[15] = 32'h99c7689e;
        for (int i = 2; i < 15; i++) kbuf[i] = 32'h11111111 * i;
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = kbuf[i];
            exp_key[511 - 32*i -: 32] = kbuf[i];
        end
        wr(12'h150, 15, resp);
        chk("key_bresp", resp, 2'b00);
        chk("core_key", core_key_o, exp_key);

        wbuf[0] = 32'h88866d5a; wbuf[15] = 32'h4f09d21b;
        for (int i = 1; i < 15; i++) wbuf[i] = 32'h5a5a0000 + i;
        base = din_n;
        wr(12'h140, 15, resp);
        chk("din_bresp", resp, 2'b00);
        chk("din_count", din_n - base, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("din_word%0d", i), din_log[base + i], wbuf[i]);

        core_busy_i = 1'b1; core_din_ready_i = 1'b0;
        base = din_n;
        wr(12'h140, 3, resp);
        chk("drop_bresp", resp, 2'b10);
        chk("drop_count", din_n - base, 0);
        core_busy_i = 1'b0; core_din_ready_i = 1'b1;
        wr(12'h140, 3, resp);
        chk("retry_bresp", resp, 2'b00);
        chk("retry_count", din_n - base, 4);
        chk("retry_word3", din_log[base + 3], wbuf[3]);

        @(negedge aclk); core_done_i = 1'b1;
        @(negedge aclk); core_done_i = 1'b0; #1;
        chk("irq_set", irq, 1);
        rd(12'h030, 0, -1);
        chk("sts_done", rbuf[0], 32'h1);
        core_busy_i = 1'b1;
        rd(12'h030, 0, -1);
        chk("sts_busy_done", rbuf[0], 32'h11);
        core_busy_i = 1'b0;
        done_on_w = 1'b1; wbuf[0] = 32'h2; wr(12'h020, 0, resp); done_on_w = 1'b0;
        chk("done_set_wins", irq, 1);
        wr(12'h020, 0, resp);
        chk("irq_clr", irq, 0);
        chk("core_last", core_last_o, 1);

        rd(12'h100, 15, 5);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("hash%0d", i), {rrsp[i], rlst[i], rbuf[i]}, {2'b00, i == 15, dbuf[i]});
        end
        rd(12'h140, 0, -1);
        chk("din_read_slverr", {rrsp[0], rbuf[0]}, {2'b10, 32'h0});
        wbuf[0] = 32'h1234; wr(12'h200, 0, resp);
        chk("unmapped_bresp", resp, 2'b10);

        wbuf[0] = 32'h3; wbuf[1] = 32'h7; wbuf[2] = 32'h9;
        wr(12'h010, 2, resp);
        rd(12'h010, 0, -1);
        chk("cfg_extra_beats", {resp, rbuf[0]}, {2'b00, 32'h3});

        @(negedge aclk); random_i = 4'ha;
        @(negedge aclk); #1;
        chk("random_fwd", core_random_o, 4'ha);

        @(negedge aclk); core_done_i = 1'b1;
        @(negedge aclk); core_done_i = 1'b0;
        wbuf[0] = 32'h80000000; wr(12'h010, 0, resp);
        chk("srst_clears", {irq, core_key_o, core_last_o}, 0);

        @(negedge aclk);
        axi.araddr = 12'h100; axi.arlen = 8'd3; axi.arburst = 2'b01; axi.arvalid = 1'b1;
        @(posedge aclk); @(negedge aclk);
        axi.arvalid = 1'b0; #1;
        chk("midburst_rvalid", axi.rvalid, 1);
        areset = 1'b1; #1;
        chk("midburst_rst", {axi.rvalid, axi.arready, axi.bvalid}, 0);
        @(negedge aclk); areset = 1'b0;
        @(negedge aclk); #1;
        chk("post_rst_idle", {axi.awready, axi.arready, axi.rvalid}, 3'b110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
